// File: rtl/serial_adder.sv
// Bit-serial adder: captures a/b/cin, adds one bit per clock LSB-first,
// then holds sum/cout in DONE until the consumer accepts them.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_sum;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic             w_s, w_c, w_last;
    logic [WIDTH:0]   w_sum_ext;

    assign w_s       = r_a[0] ^ r_b[0] ^ r_carry;
    assign w_c       = (r_a[0] & r_b[0]) | (r_b[0] & r_carry) | (r_a[0] & r_carry);
    assign w_last    = (r_cnt == CW'(WIDTH - 1));
    // New bit enters at the MSB; the concatenation keeps WIDTH=1 legal.
    assign w_sum_ext = {w_s, r_sum};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_next = S_SHIFT;
            S_SHIFT: if (w_last)    w_next = S_DONE;
            S_DONE:  if (out_ready) w_next = S_IDLE;
            default:                w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_sum   <= '0;
                        r_carry <= cin;
                        r_cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_sum   <= w_sum_ext[WIDTH:1];
                    r_carry <= w_c;
                    if (!w_last) r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign sum       = r_sum;
    assign cout      = r_carry;
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed table, backpressure,
// mid-operation reset, WIDTH=1 and 1000 random back-to-back operations.
module tb_serial_adder;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid, out_ready, cin;
    logic [W-1:0] a, b;
    logic         in_ready, out_valid, cout, busy;
    logic [W-1:0] sum;

    logic         in_valid1, out_ready1, cin1, a1, b1;
    logic         in_ready1, out_valid1, cout1, busy1, sum1;

    serial_adder #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .busy(busy)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1), .busy(busy1)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one operation on the WIDTH=8 instance and returns result and latency.
    task automatic run8(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                        output logic [7:0] rs, output logic rc, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin step(); n++; end
        if (!in_ready) chk("run8_ready_timeout", 0, 1);
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            step(); lat++;
        end
        rs = sum; rc = cout;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("run8_idle_after_accept", {31'd0, in_ready}, 1);
    endtask

    task automatic run1(input logic va, input logic vb, input logic vc,
                        output logic rs, output logic rc, output int lat);
        a1 = va; b1 = vb; cin1 = vc; in_valid1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        lat = 0;
        while (!out_valid1 && lat < 10) begin step(); lat++; end
        rs = sum1; rc = cout1;
        out_ready1 = 1'b1;
        step();
        out_ready1 = 1'b0;
        chk("run1_idle_after_accept", {31'd0, in_ready1}, 1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
    } op_t;

    vec_t tbl[7];
    op_t  q[$];

    initial begin
        logic [7:0] rs;
        logic       rc, rs1;
        int         lat, cyc, last, ncap;
        op_t        op;
        logic [8:0] e;

        tbl[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        tbl[1] = '{8'h5A, 8'hA5, 1'b1, 8'h00, 1'b1};
        tbl[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        tbl[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        tbl[4] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
        tbl[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        tbl[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};

        rst_n = 1'b0;
        in_valid = 0; out_ready = 0; a = '0; b = '0; cin = 0;
        in_valid1 = 0; out_ready1 = 0; a1 = 0; b1 = 0; cin1 = 0;
        #2;
        chk("rst_in_ready", {31'd0, in_ready}, 1);
        chk("rst_out_valid", {31'd0, out_valid}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_sum", {24'd0, sum}, 0);
        chk("rst_cout", {31'd0, cout}, 0);
        chk("rst1_in_ready", {31'd0, in_ready1}, 1);
        step(); step();
        rst_n = 1'b1;
        step();

        foreach (tbl[i]) begin
            run8(tbl[i].a, tbl[i].b, tbl[i].cin, rs, rc, lat);
            chk("tbl_latency", lat, W);
            chk("tbl_sum", {24'd0, rs}, {24'd0, tbl[i].s});
            chk("tbl_cout", {31'd0, rc}, {31'd0, tbl[i].co});
        end

        // Backpressure: result must hold while inputs churn.
        a = 8'h12; b = 8'h34; cin = 0; in_valid = 1;
        step();
        lat = 0;
        while (!out_valid && lat < 40) begin
            in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
            step(); lat++;
        end
        chk("bp_latency", lat, W);
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'($urandom); a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            step();
            chk("bp_sum", {24'd0, sum}, 32'h46);
            chk("bp_cout", {31'd0, cout}, 0);
            chk("bp_in_ready", {31'd0, in_ready}, 0);
            chk("bp_out_valid", {31'd0, out_valid}, 1);
        end
        in_valid = 0; out_ready = 1;
        step();
        out_ready = 0;
        chk("bp_release_idle", {31'd0, in_ready}, 1);
        chk("bp_release_ov", {31'd0, out_valid}, 0);

        // Reset after three SHIFT edges.
        a = 8'hFF; b = 8'h01; cin = 0; in_valid = 1;
        step();
        in_valid = 0;
        step(); step(); step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", {31'd0, in_ready}, 1);
        chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
        chk("mid_rst_busy", {31'd0, busy}, 0);
        chk("mid_rst_sum", {24'd0, sum}, 0);
        chk("mid_rst_cout", {31'd0, cout}, 0);
        step(); step();
        rst_n = 1'b1;
        lat = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            if (out_valid || busy) lat++;
        end
        chk("mid_rst_no_pulse", lat, 0);
        run8(8'h03, 8'h04, 1'b0, rs, rc, lat);
        chk("post_rst_latency", lat, W);
        chk("post_rst_sum", {24'd0, rs}, 32'h07);
        chk("post_rst_cout", {31'd0, rc}, 0);

        // WIDTH=1 instance.
        run1(1'b1, 1'b1, 1'b1, rs1, rc, lat);
        chk("w1_latency", lat, 1);
        chk("w1_sum", {31'd0, rs1}, 1);
        chk("w1_cout", {31'd0, rc}, 1);
        run1(1'b0, 1'b1, 1'b0, rs1, rc, lat);
        chk("w1_sum_b", {31'd0, rs1}, 1);
        chk("w1_cout_b", {31'd0, rc}, 0);
        run1(1'b1, 1'b0, 1'b1, rs1, rc, lat);
        chk("w1_sum_c", {31'd0, rs1}, 0);
        chk("w1_cout_c", {31'd0, rc}, 1);

        // Back-to-back random stream against an arithmetic reference.
        in_valid = 1; out_ready = 1;
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
        cyc = 0; last = 0; ncap = 0;
        while ((ncap < 1000 || q.size() > 0) && cyc < 20000) begin
            if (in_ready && in_valid) begin
                q.push_back('{a, b, cin});
                if (ncap > 0) chk("b2b_spacing", cyc - last, W + 2);
                last = cyc;
                ncap++;
            end
            step(); cyc++;
            if (ncap == 1000) in_valid = 0;
            if (out_valid) begin
                if (q.size() == 0) chk("b2b_spurious", 1, 0);
                else begin
                    op = q.pop_front();
                    e = {1'b0, op.a} + {1'b0, op.b} + 9'(op.cin);
                    chk("b2b_sum", {24'd0, sum}, {24'd0, e[7:0]});
                    chk("b2b_cout", {31'd0, cout}, {31'd0, e[8]});
                end
            end
            if (in_ready) begin
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            end
        end
        chk("b2b_completed", ncap, 1000);
        chk("b2b_drained", q.size(), 0);
        out_ready = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, operand/sum width in bits; legal range 1..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset; asserting it immediately forces the reset state, and deasserting it takes effect on the next rising clk edge.
REQ-004 in_valid  input  1  upstream asserts that a, b and cin hold a valid operation.
REQ-005 in_ready  output  1  block can accept an operation this cycle.
REQ-006 a  input  WIDTH  operand A, unsigned.
REQ-007 b  input  WIDTH  operand B, unsigned.
REQ-008 cin  input  1  carry-in for bit 0.
REQ-009 out_valid  output  1  sum and cout hold a completed result.
REQ-010 out_ready  input  1  downstream accepts the result this cycle.
REQ-011 sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
REQ-012 cout  output  1  carry out of bit WIDTH-1.
REQ-013 busy  output  1  high in SHIFT and DONE states.

Function
REQ-014 The block SHALL be a three-state FSM: IDLE, SHIFT, DONE.
REQ-015 in_ready SHALL be 1 exactly when the state is IDLE; out_valid SHALL be 1 exactly when the state is DONE.
REQ-016 IDLE: on an edge with in_valid=1, the block SHALL capture a, b and cin into internal shift and carry registers, clear the bit counter, and go to SHIFT.
REQ-017 SHIFT: each edge SHALL form one full-adder bit from the LSBs of the A/B shift registers and the carry register: s = a0^b0^c, c_next = a0&b0 | b0&c | a0&c.
REQ-018 In SHIFT, the A/B registers SHALL shift right by one; s SHALL enter the sum register at the MSB, with the sum register shifting right; the carry register SHALL load c_next.
REQ-019 The bit counter SHALL increment once per SHIFT edge; on the edge that processes bit WIDTH-1, the FSM SHALL go to DONE.
REQ-020 Latency: if the capture edge is edge 0, bits are processed on edges 1..WIDTH, and out_valid SHALL be high after edge WIDTH.
REQ-021 DONE: sum SHALL equal the full WIDTH-bit result and cout SHALL equal the final carry; both SHALL be held stable while out_ready=0.
REQ-022 DONE with out_ready=1 on an edge SHALL return the FSM to IDLE; the earliest next capture is the following edge, so the minimum issue interval is WIDTH+2 cycles.
REQ-023 In SHIFT and DONE, in_valid, a, b and cin SHALL be ignored; changes to them SHALL NOT affect the result in flight.
REQ-024 out_ready SHALL be ignored outside DONE.
REQ-025 sum and cout SHALL be driven directly from registers, with no combinational path from any input.
REQ-026 WIDTH=1 SHALL work: a single SHIFT edge, then DONE.
REQ-027 The counter width SHALL be sufficient to count to WIDTH-1 without wrap-around; the counter SHALL be cleared on every capture.

Reset
REQ-028 While rst_n=0: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, and the carry, counter and shift registers SHALL all be 0.
REQ-029 Reset asserted in SHIFT or DONE SHALL abort the operation in flight; no out_valid pulse SHALL follow the release of reset.
REQ-030 The first capture after reset release SHALL occur no earlier than the first rising edge on which rst_n=1.

Verification
REQ-031 WIDTH=8, a=8'hFF, b=8'h01, cin=0 -> out_valid high 8 edges after capture, sum=8'h00, cout=1.
REQ-032 WIDTH=8, a=8'h5A, b=8'hA5, cin=1 -> sum=8'h00, cout=1; with a=8'h12, b=8'h34, cin=0 -> sum=8'h46, cout=0.
REQ-033 Backpressure: hold out_ready=0 for 5 cycles in DONE and toggle a/b/in_valid throughout -> sum/cout stable, in_ready=0; release out_ready -> IDLE on the next edge.
REQ-034 Reset mid-operation: assert rst_n=0 after 3 SHIFT edges -> outputs match REQ-028 immediately; new operation 8'h03+8'h04+0 -> sum=8'h07, cout=0.
REQ-035 Back-to-back with out_ready tied 1 and in_valid tied 1, random operands over 1000 operations -> every result matches a+b+cin, and captures are spaced exactly WIDTH+2 cycles apart.
REQ-036 WIDTH=1: a=1, b=1, cin=1 -> sum=1, cout=1, out_valid on the edge after capture +1.
